seq_accum16: RTL and testbench



---
 rtl/seq_accum16_if.sv | 29 ++
 rtl/seq_accum16.sv | 144 ++++++++++++++
 tb/tb_seq_accum16.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seq_accum16_if.sv
// Streaming handshake bundle for seq_accum16: job control, operand input
// channel and result output channel.
interface seq_accum16_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic             mode;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_sum;
    logic             out_flag;
    logic             busy;

    // Producer/consumer side that drives jobs and operands into the accumulator.
    modport master (
        output start, mode, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_flag, busy
    );

    // Accumulator side.
    modport slave (
        input  start, mode, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_flag, busy
    );
endinterface

// File: rtl/seq_accum16.sv
// Sequential multi-operand accumulator: folds a stream of 16-bit operands into
// a sum or difference through one ripple-carry adder, with a sticky carry/borrow.

module rca16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_c_in,
    output logic [15:0] o_sum,
    output logic        o_c_out
);
    logic [16:0] w_c;

    assign w_c[0] = i_c_in;

    for (genvar gi = 0; gi < 16; gi++) begin : g_fa
        assign o_sum[gi]   = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi + 1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_c_out = w_c[16];
endmodule

module seq_accum16 #(
    parameter int LEN_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_accum16_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_acc;
    logic [15:0]      w_acc_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic             r_flag;
    logic             w_flag_nxt;
    logic             r_mode;
    logic             w_mode_nxt;
    logic             r_first;
    logic             w_first_nxt;

    logic [15:0]      w_b;
    logic [15:0]      w_sum;
    logic             w_c_out;
    logic             w_accept;

    // Subtraction is a + ~b + 1, so the latched mode doubles as the carry-in.
    assign w_b = r_mode ? ~bus.in_data : bus.in_data;

    rca16 u_rca16 (
        .i_a     (r_acc),
        .i_b     (w_b),
        .i_c_in  (r_mode),
        .o_sum   (w_sum),
        .o_c_out (w_c_out)
    );

    assign w_accept = (r_state == S_ACC) && bus.in_valid;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_flag_nxt    = r_flag;
        w_mode_nxt    = r_mode;
        w_first_nxt   = r_first;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;

        case (r_state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    w_acc_nxt   = '0;
                    w_flag_nxt  = 1'b0;
                    w_cnt_nxt   = bus.len;
                    w_mode_nxt  = bus.mode;
                    w_first_nxt = 1'b1;
                    w_state_nxt = (bus.len == '0) ? S_DONE : S_ACC;
                end
            end

            S_ACC: begin
                bus.in_ready = 1'b1;
                if (w_accept) begin
                    if (r_first) begin
                        // The first operand is loaded as-is, even when subtracting.
                        w_acc_nxt   = bus.in_data;
                        w_first_nxt = 1'b0;
                    end else begin
                        w_acc_nxt  = w_sum;
                        w_flag_nxt = r_flag | (r_mode ? ~w_c_out : w_c_out);
                    end
                    w_cnt_nxt = r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_flag  <= 1'b0;
            r_mode  <= 1'b0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flag  <= w_flag_nxt;
            r_mode  <= w_mode_nxt;
            r_first <= w_first_nxt;
        end
    end

    assign bus.out_sum  = r_acc;
    assign bus.out_flag = r_flag;
endmodule

// File: tb/tb_seq_accum16.sv
// Directed self-checking bench for seq_accum16 with hand-computed results.
module tb_seq_accum16;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    seq_accum16_if #(.LEN_W(8)) bus ();

    seq_accum16 #(.LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic m, input logic [7:0] l);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.len   = l;
        tick();
        bus.start = 1'b0;
        bus.mode  = ~m;
        bus.len   = 8'hFF;
        check("start_busy", bus.busy, 1);
        check("start_in_ready", bus.in_ready, (l != 0));
    endtask

    task automatic send(input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hDEAD;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("gap_in_ready", bus.in_ready, 1);
            check("gap_out_valid", bus.out_valid, 0);
        end
    endtask

    task automatic expect_result(input string tag, input logic [15:0] s, input logic f);
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_sum"}, bus.out_sum, s);
        check({tag, "_flag"}, bus.out_flag, f);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_consumed"}, bus.out_valid, 0);
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sum", bus.out_sum, 16'h0000);
        check("rst_flag", bus.out_flag, 0);

        // Mode 0 basic: 1+2+3+4, result visible right after the 4th accept.
        start_job(1'b0, 8'd4);
        send(16'd1);
        send(16'd2);
        send(16'd3);
        send(16'd4);
        expect_result("m0_basic", 16'h000A, 1'b0);

        // Mode 0 carry: 0xFFFF + 2 wraps to 1 with carry.
        start_job(1'b0, 8'd2);
        send(16'hFFFF);
        send(16'h0002);
        expect_result("m0_carry", 16'h0001, 1'b1);

        // Mode 1 difference: 10 - 3 - 2.
        start_job(1'b1, 8'd3);
        send(16'd10);
        send(16'd3);
        send(16'd2);
        expect_result("m1_diff", 16'h0005, 1'b0);

        // Mode 1 borrow: 1 - 2.
        start_job(1'b1, 8'd2);
        send(16'd1);
        send(16'd2);
        expect_result("m1_borrow", 16'hFFFF, 1'b1);

        // Stalls, ignored start during ACC, then output backpressure.
        start_job(1'b0, 8'd3);
        gap(2);
        send(16'h1000);
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        bus.len   = 8'd0;
        tick();
        bus.start = 1'b0;
        check("acc_start_ignored_busy", bus.busy, 1);
        check("acc_start_ignored_ready", bus.in_ready, 1);
        check("acc_start_ignored_valid", bus.out_valid, 0);
        send(16'h2000);
        gap(3);
        send(16'hF000);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_sum", bus.out_sum, 16'h2000);
            check("hold_flag", bus.out_flag, 1);
            bus.start = (i == 2);
            tick();
            bus.start = 1'b0;
        end
        expect_result("stall", 16'h2000, 1'b1);

        // Zero-length job completes one cycle after start with a cleared result.
        start_job(1'b0, 8'd0);
        expect_result("len0", 16'h0000, 1'b0);

        // Reset mid-job drops the in-flight operand and clears everything.
        start_job(1'b0, 8'd4);
        send(16'd7);
        send(16'd9);
        check("mid_sum", bus.out_sum, 16'd16);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd5;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("mrst_in_ready", bus.in_ready, 0);
        check("mrst_out_valid", bus.out_valid, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_sum", bus.out_sum, 16'h0000);
        check("mrst_flag", bus.out_flag, 0);
        start_job(1'b0, 8'd2);
        send(16'd5);
        send(16'd6);
        expect_result("after_rst", 16'h000B, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
